// File: rtl/bit_count_pkg.sv
// Shared types and helpers for the bit-count controller and its datapath.
package bit_count_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Count width able to hold the value n itself.
  function automatic int unsigned cw_of(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bit_count_ctrl_if.sv
// User-facing start/data/result/status bundle of the bit-count controller.
interface bit_count_ctrl_if
  import bit_count_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = cw_of(N)
);

  logic          s;
  logic [N-1:0]  Data;
  logic [CW-1:0] B;
  logic          Done;
  logic          Busy;

  modport master (output s, output Data, input B, input Done, input Busy);
  modport slave  (input s, input Data, output B, output Done, output Busy);

endinterface

// File: rtl/bit_count_dp.sv
// Shift-register/counter datapath: A shifts right toward A[0], B counts ones.
module bit_count_dp #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 3
) (
  input  logic          Clk,
  input  logic          Resetn,
  input  logic          LA,
  input  logic          EA,
  input  logic          LB,
  input  logic          EB,
  input  logic [N-1:0]  Data,
  output logic          a0,
  output logic          z,
  output logic [CW-1:0] B
);

  logic [N-1:0]  a_q;
  logic [CW-1:0] b_q;

  // Load wins over shift.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      a_q <= '0;
    end else if (LA) begin
      a_q <= Data;
    end else if (EA) begin
      a_q <= a_q >> 1;
    end
  end

  // Clear wins over increment.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      b_q <= '0;
    end else if (LB) begin
      b_q <= '0;
    end else if (EB) begin
      b_q <= b_q + CW'(1);
    end
  end

  assign a0 = a_q[0];
  assign z  = (a_q == '0);
  assign B  = b_q;

endmodule

// File: rtl/bit_count_ctrl.sv
// Bit-count sequencer: accepts a word on start, steps the datapath until A
// is empty, then holds the ones count with Done until start drops.
module bit_count_ctrl
  import bit_count_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = cw_of(N)
) (
  input logic             Clk,
  input logic             Resetn,
  bit_count_ctrl_if.slave bus
);

  state_e        state_q;
  state_e        state_n;
  logic          la;
  logic          ea;
  logic          lb;
  logic          eb;
  logic          a0;
  logic          z;
  logic          done_q;
  logic          busy_q;
  logic [CW-1:0] b;

  // Next-state and strobe decode.
  always_comb begin
    state_n = state_q;
    la      = 1'b0;
    ea      = 1'b0;
    lb      = 1'b0;
    eb      = 1'b0;
    case (state_q)
      S_IDLE: begin
        lb = 1'b1;
        if (bus.s) begin
          la      = 1'b1;
          state_n = S_COUNT;
        end
      end
      S_COUNT: begin
        if (z) begin
          state_n = S_DONE;
        end else begin
          ea = 1'b1;
          eb = a0;
        end
      end
      S_DONE: begin
        if (!bus.s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Status flops track the state they decode, so they change on the same edge.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      busy_q  <= (state_n == S_COUNT);
      done_q  <= (state_n == S_DONE);
    end
  end

  bit_count_dp #(
    .N  (N),
    .CW (CW)
  ) u_dp (
    .Clk    (Clk),
    .Resetn (Resetn),
    .LA     (la),
    .EA     (ea),
    .LB     (lb),
    .EB     (eb),
    .Data   (bus.Data),
    .a0     (a0),
    .z      (z),
    .B      (b)
  );

  assign bus.B    = b;
  assign bus.Done = done_q;
  assign bus.Busy = busy_q;

endmodule

// File: tb/tb_bit_count_ctrl.sv
// Bench for bit_count_ctrl at N=4 and N=8 against a latency/popcount model.
module tb_bit_count_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  bit_count_ctrl_if #(.N(4)) b4 ();
  bit_count_ctrl_if #(.N(8)) b8 ();

  bit_count_ctrl #(.N(4)) u_dut4 (.Clk(clk), .Resetn(rst_n), .bus(b4.slave));
  bit_count_ctrl #(.N(8)) u_dut8 (.Clk(clk), .Resetn(rst_n), .bus(b8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Cycles from the accepting edge to Done: index of the top set bit plus 2.
  function automatic int exp_lat(input logic [7:0] d);
    int m;
    m = -1;
    for (int i = 0; i < 8; i++) if (d[i]) m = i;
    return (m < 0) ? 1 : m + 2;
  endfunction

  function automatic int exp_ones(input logic [7:0] d);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) c += int'(d[i]);
    return c;
  endfunction

  task automatic set_in(input int w, input logic s, input logic [7:0] d);
    if (w == 4) begin
      b4.s = s; b4.Data = d[3:0];
    end else begin
      b8.s = s; b8.Data = d;
    end
  endtask

  task automatic set_s(input int w, input logic s);
    if (w == 4) b4.s = s;
    else        b8.s = s;
  endtask

  task automatic get_out(input int w, output int b, output logic done, output logic busy);
    if (w == 4) begin
      b = int'(b4.B); done = b4.Done; busy = b4.Busy;
    end else begin
      b = int'(b8.B); done = b8.Done; busy = b8.Busy;
    end
  endtask

  // Starts a count from the low clock phase; returns at the negedge Done is seen.
  task automatic run_count(input int w, input logic [7:0] d, input bit hold,
                           output int lat, output int busy_n, output int b);
    int   bb;
    logic dn;
    logic bs;
    set_in(w, 1'b1, d);
    lat = -1; busy_n = 0; b = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0 && !hold) set_s(w, 1'b0);
      get_out(w, bb, dn, bs);
      if (bs) busy_n++;
      if (dn) begin
        lat = i; b = bb;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int   b;
    logic dn, bs;
    rst_n = 1'b0;
    set_in(4, 1'b0, 8'h00);
    set_in(8, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    for (int w = 4; w <= 8; w += 4) begin
      get_out(w, b, dn, bs);
      n_tests++;
      if (b !== 0 || dn !== 1'b0 || bs !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_w%0d: got B=%0d Done=%b Busy=%b expected 0/0/0", w, b, dn, bs);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bn, b, b2;
    logic dn, bs;
    run_count(4, 8'h0B, 1'b0, lat, bn, b);
    n_tests++;
    if (lat !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    n_tests++;
    if (bn !== 5) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 5", bn); end
    n_tests++;
    if (b !== 3) begin n_fail++; $display("FAIL basic_count: got %0d expected 3", b); end
    @(negedge clk);
    get_out(4, b2, dn, bs);
    n_tests++;
    if (dn !== 1'b0 || bs !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_fall: got Done=%b Busy=%b expected 0/0", dn, bs);
    end
  endtask

  task automatic test_zero();
    int lat, bn, b, b2;
    logic dn, bs;
    run_count(4, 8'h00, 1'b0, lat, bn, b);
    n_tests++;
    if (lat !== 1 || bn !== 1 || b !== 0) begin
      n_fail++;
      $display("FAIL zero_word: got lat=%0d busy=%0d B=%0d expected 1/1/0", lat, bn, b);
    end
    @(negedge clk);
    get_out(4, b2, dn, bs);
    n_tests++;
    if (dn !== 1'b0) begin n_fail++; $display("FAIL zero_done_fall: got %b expected 0", dn); end
  endtask

  task automatic test_hold();
    int lat, bn, b, b2;
    logic dn, bs;
    run_count(4, 8'h0F, 1'b1, lat, bn, b);
    n_tests++;
    if (lat !== 5 || b !== 4) begin
      n_fail++; $display("FAIL hold_count: got lat=%0d B=%0d expected 5/4", lat, b);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      get_out(4, b2, dn, bs);
      n_tests++;
      if (dn !== 1'b1 || bs !== 1'b0 || b2 !== 4) begin
        n_fail++;
        $display("FAIL hold_no_retrigger: got Done=%b Busy=%b B=%0d expected 1/0/4", dn, bs, b2);
      end
    end
    set_s(4, 1'b0);
    @(negedge clk);
    get_out(4, b2, dn, bs);
    n_tests++;
    if (dn !== 1'b0) begin n_fail++; $display("FAIL hold_release: got Done=%b expected 0", dn); end
  endtask

  task automatic test_data_change();
    int   lat, b, bb;
    logic dn, bs;
    set_in(4, 1'b1, 8'h08);
    lat = -1; b = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      get_out(4, bb, dn, bs);
      if (dn) begin lat = i; b = bb; break; end
      set_in(4, i[0], 8'($urandom));
    end
    n_tests++;
    if (lat !== 5 || b !== 1) begin
      n_fail++; $display("FAIL data_change: got lat=%0d B=%0d expected 5/1", lat, b);
    end
    set_s(4, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int   lat, bn, b;
    logic dn, bs;
    set_in(4, 1'b1, 8'h0F);
    @(negedge clk);
    set_s(4, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    get_out(4, b, dn, bs);
    n_tests++;
    if (b !== 0 || dn !== 1'b0 || bs !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got B=%0d Done=%b Busy=%b expected 0/0/0", b, dn, bs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_count(4, 8'h06, 1'b0, lat, bn, b);
    n_tests++;
    if (lat !== 4 || b !== 2) begin
      n_fail++; $display("FAIL after_reset_count: got lat=%0d B=%0d expected 4/2", lat, b);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int   lat, bn, b, b2;
    logic dn, bs;
    run_count(8, 8'hFF, 1'b1, lat, bn, b);
    n_tests++;
    if (lat !== 9 || b !== 8) begin
      n_fail++; $display("FAIL b2b_first: got lat=%0d B=%0d expected 9/8", lat, b);
    end
    set_s(8, 1'b0);
    @(negedge clk);
    get_out(8, b2, dn, bs);
    n_tests++;
    if (dn !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got Done=%b expected 0", dn); end
    run_count(8, 8'h80, 1'b1, lat, bn, b);
    n_tests++;
    if (lat !== 9 || b !== 1) begin
      n_fail++; $display("FAIL b2b_second: got lat=%0d B=%0d expected 9/1", lat, b);
    end
    set_s(8, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_random();
    int         w, lat, bn, b, b2;
    logic [7:0] d;
    bit         hold;
    logic       dn, bs;
    for (int k = 0; k < 24; k++) begin
      w    = ($urandom % 2 == 0) ? 4 : 8;
      d    = 8'($urandom);
      if (w == 4) d = d & 8'h0F;
      hold = 1'($urandom % 2);
      run_count(w, d, hold, lat, bn, b);
      n_tests++;
      if (lat !== exp_lat(d) || bn !== exp_lat(d) || b !== exp_ones(d)) begin
        n_fail++;
        $display("FAIL random_w%0d_d%02h: got lat=%0d busy=%0d B=%0d expected %0d/%0d/%0d",
                 w, d, lat, bn, b, exp_lat(d), exp_lat(d), exp_ones(d));
      end
      set_s(w, 1'b0);
      @(negedge clk);
      get_out(w, b2, dn, bs);
      n_tests++;
      if (dn !== 1'b0 || bs !== 1'b0) begin
        n_fail++; $display("FAIL random_release: got Done=%b Busy=%b expected 0/0", dn, bs);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    set_in(4, 1'b0, 8'h00);
    set_in(8, 1'b0, 8'h00);
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero();
    test_hold();
    test_data_change();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
